// File: rtl/pipe_rate_pwr_ctrl.sv
// pipe_rate_pwr_ctrl: MAC-side sequencer for PIPE Rate/PowerDown changes.
// It takes one request at a time and forces TxElecIdle for EI_CYCLES clocks.
// It then drives the new Rate/PowerDown pair and waits for the PhyStatus
// completion pulse, ending with a done pulse or a sticky timeout error.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and req_* are ignored while req_valid is low.
// All outputs are registered.
module pipe_rate_pwr_ctrl #(
    parameter int EI_CYCLES = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_rate,
    input  logic [1:0] req_powerdown,
    output logic [1:0] pipe_rate,
    output logic [1:0] pipe_powerdown,
    output logic       pipe_txelecidle,
    input  logic       phy_status,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       illegal_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_RST_WAIT = 3'd0,
        S_IDLE     = 3'd1,
        S_EI       = 3'd2,
        S_APPLY    = 3'd3,
        S_WAIT_PHY = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] EI_LAST  = CNT_W'(EI_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       RATE_BAD = 2'd3;
    localparam logic [1:0]       PD_P0    = 2'd0;
    localparam logic [1:0]       PD_P1    = 2'd2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       lat_rate_q, lat_rate_d;
    logic [1:0]       lat_pd_q, lat_pd_d;
    logic [1:0]       rate_d, pd_d;
    logic             eidle_d, done_d, tmo_d, ill_d;

    // Counter never wraps: it holds at all-ones.
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST_WAIT;
        else        state_q <= state_d;
    end

    // Next-state and next-output logic; each state's actions land on its exit edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rate_d = lat_rate_q;
        lat_pd_d   = lat_pd_q;
        rate_d     = pipe_rate;
        pd_d       = pipe_powerdown;
        eidle_d    = pipe_txelecidle;
        tmo_d      = timeout_err;
        done_d     = 1'b0;
        ill_d      = 1'b0;
        case (state_q)
            S_RST_WAIT: begin
                if (!phy_status) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_rate == RATE_BAD) begin
                        ill_d = 1'b1;
                    end else if (req_rate == pipe_rate && req_powerdown == pipe_powerdown) begin
                        done_d = 1'b1;
                    end else begin
                        lat_rate_d = req_rate;
                        lat_pd_d   = req_powerdown;
                        tmo_d      = 1'b0;
                        cnt_d      = '0;
                        eidle_d    = 1'b1;
                        state_d    = S_EI;
                    end
                end
            end
            S_EI: begin
                eidle_d = 1'b1;
                if (cnt_q == EI_LAST) state_d = S_APPLY;
                else                  cnt_d   = cnt_inc;
            end
            S_APPLY: begin
                rate_d  = lat_rate_q;
                pd_d    = lat_pd_q;
                cnt_d   = '0;
                state_d = S_WAIT_PHY;
            end
            S_WAIT_PHY: begin
                // PhyStatus takes priority over the timeout compare.
                if (phy_status) begin
                    state_d = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                eidle_d = (lat_pd_q != PD_P0);
                state_d = S_IDLE;
            end
            default: state_d = S_RST_WAIT;
        endcase
    end

    // Registered outputs, latched request and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            lat_rate_q      <= '0;
            lat_pd_q        <= PD_P1;
            pipe_rate       <= '0;
            pipe_powerdown  <= PD_P1;
            pipe_txelecidle <= 1'b1;
            req_ready       <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            illegal_err     <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            lat_rate_q      <= lat_rate_d;
            lat_pd_q        <= lat_pd_d;
            pipe_rate       <= rate_d;
            pipe_powerdown  <= pd_d;
            pipe_txelecidle <= eidle_d;
            req_ready       <= (state_d == S_IDLE);
            busy            <= (state_d != S_IDLE);
            done            <= done_d;
            timeout_err     <= tmo_d;
            illegal_err     <= ill_d;
        end
    end

endmodule

// File: tb/tb_pipe_rate_pwr_ctrl.sv
// Bench for pipe_rate_pwr_ctrl: directed table, reset sequences, random requests.
module tb_pipe_rate_pwr_ctrl;

    localparam int EI  = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_rate;
    logic [1:0] req_powerdown;
    logic [1:0] pipe_rate;
    logic [1:0] pipe_powerdown;
    logic       pipe_txelecidle;
    logic       phy_status;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       illegal_err;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    pipe_rate_pwr_ctrl #(.EI_CYCLES(EI), .TIMEOUT(TMO), .CNT_W(11)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rate        (req_rate),
        .req_powerdown   (req_powerdown),
        .pipe_rate       (pipe_rate),
        .pipe_powerdown  (pipe_powerdown),
        .pipe_txelecidle (pipe_txelecidle),
        .phy_status      (phy_status),
        .busy            (busy),
        .done            (done),
        .timeout_err     (timeout_err),
        .illegal_err     (illegal_err),
        .dbg_state       (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        int rate; int pd; int k;
        int lat; int ill;
        int er; int ep; int ee; int et;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/rate"},  int'(pipe_rate), 0);
        check({tag, "/pd"},    int'(pipe_powerdown), 2);
        check({tag, "/eidle"}, int'(pipe_txelecidle), 1);
        check({tag, "/ready"}, int'(req_ready), 0);
        check({tag, "/busy"},  int'(busy), 1);
        check({tag, "/done"},  int'(done), 0);
        check({tag, "/tmo"},   int'(timeout_err), 0);
        check({tag, "/ill"},   int'(illegal_err), 0);
    endtask

    // Leave RST_WAIT: PhyStatus held high for 'hold' clocks, then dropped.
    task automatic exit_rst_wait(input int hold, input string tag);
        phy_status = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        check({tag, "/still_busy"}, int'(busy), 1);
        phy_status = 1'b0;
        tick();
        check({tag, "/idle_ready"}, int'(req_ready), 1);
        check({tag, "/idle_busy"},  int'(busy), 0);
    endtask

    // One request; latency counted in edges after the accept edge (-1 = never).
    // k = clocks after the APPLY cycle's exit before PhyStatus is seen; k<0 = no PhyStatus.
    task automatic do_req(input int r, input int p, input int k, input int e_lat, input int e_ill,
                          input int e_rate, input int e_pd, input int e_eidle, input int e_tmo,
                          input string tag);
        int w;
        int done_at;
        int ill_at;
        int eidle0;
        int target;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check({tag, "/ready"}, int'(req_ready), 1);
        req_valid     = 1'b1;
        req_rate      = 2'(r);
        req_powerdown = 2'(p);
        phy_status    = 1'($urandom_range(0, 1));
        tick();
        req_valid     = 1'b0;
        req_rate      = 2'($urandom);
        req_powerdown = 2'($urandom);
        done_at = -1;
        ill_at  = -1;
        eidle0  = int'(pipe_txelecidle);
        if (done === 1'b1)        done_at = 0;
        if (illegal_err === 1'b1) ill_at  = 0;
        target = (k >= 0) ? EI + 2 + k : -100;
        for (int n = 1; n <= 60 && done_at < 0 && ill_at < 0; n++) begin
            // PhyStatus during EI/APPLY is junk that must be ignored.
            phy_status = (n == target) ? 1'b1 : (n <= EI + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (done === 1'b1)        done_at = n;
            if (illegal_err === 1'b1) ill_at  = n;
        end
        phy_status = 1'b0;
        check({tag, "/latency"}, done_at, e_lat);
        check({tag, "/illegal"}, ill_at, (e_ill != 0) ? 0 : -1);
        if (e_lat > 0) check({tag, "/eidle_forced"}, eidle0, 1);
        else           check({tag, "/eidle_kept"}, eidle0, e_eidle);
        check({tag, "/rate"},  int'(pipe_rate), e_rate);
        check({tag, "/pd"},    int'(pipe_powerdown), e_pd);
        check({tag, "/eidle"}, int'(pipe_txelecidle), e_eidle);
        check({tag, "/tmo"},   int'(timeout_err), e_tmo);
        check({tag, "/busy"},  int'(busy), 0);
        tick();
        check({tag, "/done_width"}, int'(done), 0);
        check({tag, "/ill_width"},  int'(illegal_err), 0);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int m_rate, m_pd, m_eidle, m_tmo;
        int r, p, k, lat, ill;

        // Reset and RST_WAIT exit.
        rst_n = 1'b0; req_valid = 1'b0; req_rate = '0; req_powerdown = '0; phy_status = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        exit_rst_wait(20, "rst_wait");
        check("post_reset/rate",  int'(pipe_rate), 0);
        check("post_reset/pd",    int'(pipe_powerdown), 2);
        check("post_reset/eidle", int'(pipe_txelecidle), 1);

        // Directed table, starting from rate=0, pd=P1.
        //         rate pd  k   lat ill er ep ee et
        tbl[0] = '{2,   0,  5,  12, 0,  2, 0, 0, 0};  // EI+5+3
        tbl[1] = '{2,   0, -1,  0,  0,  2, 0, 0, 0};  // same as current
        tbl[2] = '{3,   1, -1, -1,  1,  2, 0, 0, 0};  // illegal rate
        tbl[3] = '{1,   3, -1,  22, 0,  1, 3, 1, 1};  // timeout: EI+2+TMO
        tbl[4] = '{1,   3, -1,  0,  0,  1, 3, 1, 1};  // trivial keeps sticky error
        tbl[5] = '{0,   2,  0,  7,  0,  0, 2, 1, 0};  // clears error
        tbl[6] = '{0,   0,  15, 22, 0,  0, 0, 0, 0};  // PhyStatus on final compare wins
        tbl[7] = '{2,   1,  3,  10, 0,  2, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].rate, tbl[i].pd, tbl[i].k, tbl[i].lat, tbl[i].ill,
                   tbl[i].er, tbl[i].ep, tbl[i].ee, tbl[i].et, $sformatf("tbl%0d", i));
        end

        // Async reset in WAIT_PHY, then PhyStatus in IDLE is ignored.
        req_valid = 1'b1; req_rate = 2'd1; req_powerdown = 2'd1; phy_status = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (EI + 4) tick();
        check("mid/applied_rate", int'(pipe_rate), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        phy_status = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        exit_rst_wait(3, "mid_rst_wait");
        for (int i = 0; i < 3; i++) begin
            phy_status = 1'b1;
            tick();
            check("idle_phy/busy", int'(busy), 0);
            check("idle_phy/done", int'(done), 0);
        end
        phy_status = 1'b0;

        // Random requests against a transaction-level model.
        m_rate = 0; m_pd = 2; m_eidle = 1; m_tmo = 0;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            p = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin r = m_rate; p = m_pd; end
            k = ($urandom_range(0, 9) < 7) ? $urandom_range(0, TMO - 1) : -1;
            ill = 0;
            if (r == 3) begin
                lat = -1; ill = 1;
            end else if (r == m_rate && p == m_pd) begin
                lat = 0;
            end else begin
                m_tmo   = (k < 0) ? 1 : 0;
                lat     = (k < 0) ? EI + (TMO - 1) + 3 : EI + k + 3;
                m_rate  = r;
                m_pd    = p;
                m_eidle = (p != 0) ? 1 : 0;
            end
            do_req(r, p, k, lat, ill, m_rate, m_pd, m_eidle, m_tmo, $sformatf("rnd%0d", t));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                phy_status = 1'($urandom_range(0, 1));
                req_rate   = 2'($urandom);
                tick();
                check("gap/busy", int'(busy), 0);
            end
            phy_status = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
